// File: rtl/wt_cache_subsystem.sv
// ---------------------------------------------------------------------------
// wt_cache_subsystem
// Direct-mapped, write-through, no-write-allocate data cache with multi-word
// lines, sitting between a core MemRead/MemWrite port and a variable-latency
// data memory using a req/ack handshake.
//
// Ports
//   CLK, RST              clock, synchronous active-high reset
//   MemRead, MemWrite     core requests, held until stall=0 (write wins)
//   WordAddress, DataIn   core word address / write data
//   stall                 core must hold its request
//   DataOut               read data, valid when MemRead=1 and stall=0
//   mem_req, mem_we       memory request (held until mem_ack), 1=write
//   mem_addr, mem_wdata   memory word address / write data
//   mem_rdata, mem_ack    memory read data / one-cycle completion
//   hit_count, miss_count saturating read hit / miss counters
//
// Memory handshake: mem_req/mem_we/mem_addr/mem_wdata are registered and
// stay constant while mem_req=1. A transfer completes on the rising edge
// where mem_req=1 and mem_ack=1; mem_req then drops for at least one cycle.
// mem_ack is ignored whenever mem_req=0.
// ---------------------------------------------------------------------------
module wt_cache_subsystem #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int LINES          = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_W          = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] WordAddress,
    input  logic [DATA_W-1:0] DataIn,
    output logic              stall,
    output logic [DATA_W-1:0] DataOut,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int SLOT_W = IDX_W + OFF_W;
    localparam int K_W    = (OFF_W > 0) ? OFF_W : 1;
    localparam int SLOTS  = LINES * WORDS_PER_LINE;
    localparam logic [K_W-1:0]    K_LAST  = K_W'(WORDS_PER_LINE - 1);
    // Clears the offset field, giving the first word address of a line.
    localparam logic [ADDR_W-1:0] OFF_CLR = ~(ADDR_W'(WORDS_PER_LINE - 1));

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_RESP} state_t;

    // {index, offset} are the low address bits, so they directly select a
    // word slot in the flat data array.
    function automatic logic [SLOT_W-1:0] slot_of(input logic [ADDR_W-1:0] a);
        return a[SLOT_W-1:0];
    endfunction
    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return a[SLOT_W-1 -: IDX_W];
    endfunction
    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    logic [DATA_W-1:0] data_q [SLOTS];
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINES-1:0]  valid_q;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, lat_data_q, lat_data_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [CNT_W-1:0]  hit_q, hit_d, miss_q, miss_d;

    logic              arr_we, line_fill, line_inval;
    logic [SLOT_W-1:0] arr_slot;
    logic [DATA_W-1:0] arr_wdata;
    logic              req_hit, lat_hit;

    assign req_hit = valid_q[idx_of(WordAddress)] &&
                     (tag_q[idx_of(WordAddress)] == tag_of(WordAddress));
    assign lat_hit = valid_q[idx_of(lat_addr_q)] &&
                     (tag_q[idx_of(lat_addr_q)] == tag_of(lat_addr_q));

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        lat_addr_d  = lat_addr_q;
        lat_data_d  = lat_data_q;
        k_d         = k_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        stall       = 1'b0;
        DataOut     = data_q[slot_of(WordAddress)];
        arr_we      = 1'b0;
        arr_slot    = slot_of(lat_addr_q);
        arr_wdata   = lat_data_q;
        line_fill   = 1'b0;
        line_inval  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MemWrite) begin
                    stall       = 1'b1;
                    lat_addr_d  = WordAddress;
                    lat_data_d  = DataIn;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = WordAddress;
                    mem_wdata_d = DataIn;
                    state_d     = S_WRITE;
                end else if (MemRead) begin
                    if (req_hit) begin
                        hit_d = (hit_q == '1) ? hit_q : hit_q + 1'b1;
                    end else begin
                        stall      = 1'b1;
                        lat_addr_d = WordAddress;
                        miss_d     = (miss_q == '1) ? miss_q : miss_q + 1'b1;
                        k_d        = '0;
                        // Invalidate now so a partially refilled line never hits.
                        line_inval = 1'b1;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = WordAddress & OFF_CLR;
                        state_d    = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                stall = 1'b1;
                if (mem_req_q) begin
                    if (mem_ack) begin
                        arr_we    = 1'b1;
                        arr_slot  = slot_of(mem_addr_q);
                        arr_wdata = mem_rdata;
                        mem_req_d = 1'b0;
                        k_d       = k_q + 1'b1;
                        if (k_q == K_LAST) begin
                            line_fill = 1'b1;
                            state_d   = S_RESP;
                        end
                    end
                end else begin
                    // Gap cycle after an ack: issue the next word of the line.
                    mem_req_d  = 1'b1;
                    mem_addr_d = (lat_addr_q & OFF_CLR) | ADDR_W'(k_q);
                end
            end
            S_WRITE: begin
                stall = 1'b1;
                if (mem_req_q && mem_ack) begin
                    arr_we    = lat_hit;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                DataOut = data_q[slot_of(lat_addr_q)];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lat_addr_q  <= '0;
            lat_data_q  <= '0;
            k_q         <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            lat_addr_q  <= lat_addr_d;
            lat_data_q  <= lat_data_d;
            k_q         <= k_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            if (line_inval) valid_q[idx_of(WordAddress)] <= 1'b0;
            if (line_fill)  valid_q[idx_of(lat_addr_q)]  <= 1'b1;
        end
    end

    // Data and tag arrays carry no reset; writes are simply suppressed in reset.
    always_ff @(posedge CLK) begin
        if (!RST && arr_we)    data_q[arr_slot]          <= arr_wdata;
        if (!RST && line_fill) tag_q[idx_of(lat_addr_q)] <= tag_of(lat_addr_q);
    end
endmodule

// File: tb/tb_wt_cache_subsystem.sv
module tb_wt_cache_subsystem;
  localparam int LAT = 2;
  localparam int WPL = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [9:0]  WordAddress = '0;
  logic [31:0] DataIn = '0;
  logic        stall;
  logic [31:0] DataOut;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] hit_count, miss_count;

  // Narrow-counter twin; it sees identical stimulus and memory timing.
  logic        s_stall, s_mem_req, s_mem_we;
  logic [31:0] s_dout, s_mem_wdata;
  logic [9:0]  s_mem_addr;
  logic [1:0]  s_hit, s_miss;

  wt_cache_subsystem u_dut (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite),
    .WordAddress(WordAddress), .DataIn(DataIn), .stall(stall), .DataOut(DataOut),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  wt_cache_subsystem #(.CNT_W(2)) u_sat (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite),
    .WordAddress(WordAddress), .DataIn(DataIn), .stall(s_stall), .DataOut(s_dout),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(s_hit), .miss_count(s_miss)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // ---------------- memory + cache reference model ----------------
  logic [31:0] mem [1024];
  bit          mv [32];
  logic [2:0]  mt [32];
  int          m_hits = 0;
  int          m_misses = 0;
  logic [42:0] exp_q[$];   // {we, addr, wdata}
  bit          quiet = 1'b0;
  bit          prev_ack = 1'b0;
  int          acks_seen = 0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | i;
  end

  // Memory responder: ack arrives in the LAT-th cycle of mem_req being high.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge CLK); #1;
      if (RST || mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_req) begin
        cnt++;
        if (cnt >= LAT) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [42:0] e;
    forever begin
      @(posedge CLK); #3;
      if (RST) begin
        prev_ack = 1'b0;
      end else begin
        if (mem_req && mem_ack) begin
          acks_seen++;
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL bus_unexpected: got addr %h we %b expected no transfer", mem_addr, mem_we);
          end else begin
            e = exp_q.pop_front();
            chk("bus_we", {31'b0, mem_we}, {31'b0, e[42]});
            chk("bus_addr", {22'b0, mem_addr}, {22'b0, e[41:32]});
            if (e[42]) chk("bus_wdata", mem_wdata, e[31:0]);
          end
          prev_ack = 1'b1;
        end else begin
          if (prev_ack) chk("req_gap", {31'b0, mem_req}, 32'd0);
          prev_ack = 1'b0;
        end
        if (quiet) begin
          chk("hit_count", {16'b0, hit_count}, m_hits);
          chk("miss_count", {16'b0, miss_count}, m_misses);
          chk("sat_hit", {30'b0, s_hit}, sat3(m_hits));
          chk("sat_miss", {30'b0, s_miss}, sat3(m_misses));
          chk("idle_req", {31'b0, mem_req}, 32'd0);
          chk("idle_stall", {31'b0, stall}, 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Starts at a negedge; returns at the negedge after the access retires.
  task automatic access(input bit wr, input logic [9:0] a, input logic [31:0] d,
                        output int ncyc, output logic [31:0] rd);
    quiet = 1'b0;
    MemWrite = wr; MemRead = ~wr; WordAddress = a; DataIn = d;
    ncyc = 0;
    #1;
    while (stall && ncyc < 200) begin
      @(negedge CLK); #1;
      ncyc++;
    end
    if (ncyc >= 200) begin
      n_checks++; n_errors++;
      $display("FAIL stall_timeout: got stall after %0d cycles expected release", ncyc);
    end
    rd = DataOut;
    @(negedge CLK);
    MemRead = 1'b0; MemWrite = 1'b0;
    quiet = 1'b1;
  endtask

  logic [31:0] last_rd;

  task automatic do_read(input logic [9:0] a, input string nm);
    int ncyc, exp_st;
    logic [31:0] rd;
    bit hit;
    logic [4:0] idx;
    idx = a[6:2];
    hit = mv[idx] && (mt[idx] == a[9:7]);
    if (hit) exp_st = 0;
    else begin
      exp_st = WPL * LAT + WPL;
      for (int i = 0; i < WPL; i++) exp_q.push_back({1'b0, (a & 10'h3FC) | 10'(i), 32'h0});
      mv[idx] = 1'b1;
      mt[idx] = a[9:7];
    end
    access(1'b0, a, 32'h0, ncyc, rd);
    if (hit) m_hits++; else m_misses++;
    chk({nm, "_stall"}, ncyc, exp_st);
    chk({nm, "_data"}, rd, mem[a]);
    last_rd = rd;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input string nm);
    int ncyc;
    logic [31:0] rd;
    exp_q.push_back({1'b1, a, d});
    access(1'b1, a, d, ncyc, rd);
    chk({nm, "_stall"}, ncyc, LAT + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, i;
    repeat (3) @(negedge CLK);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_hits", {16'b0, hit_count}, 32'd0);
    chk("rst_misses", {16'b0, miss_count}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    quiet = 1'b1;

    // T1: cold read
    do_read(10'h005, "T1");
    chk("T1_lit_data", last_rd, 32'hC0DE0005);
    chk("T1_lit_miss", {16'b0, miss_count}, 32'd1);
    // T2: hit in the freshly filled line
    do_read(10'h006, "T2");
    chk("T2_lit_data", last_rd, 32'hC0DE0006);
    chk("T2_lit_hit", {16'b0, hit_count}, 32'd1);
    // T3: write hit, then read back
    do_write(10'h006, 32'hDEADBEEF, "T3w");
    do_read(10'h006, "T3r");
    chk("T3_lit_data", last_rd, 32'hDEADBEEF);
    // T4: write miss does not allocate
    do_write(10'h3F0, 32'h12345678, "T4w");
    do_read(10'h3F0, "T4r");
    chk("T4_lit_data", last_rd, 32'h12345678);
    chk("T4_lit_miss", {16'b0, miss_count}, 32'd2);
    // T5: conflict on index 1
    do_read(10'h005, "T5a");
    do_read(10'h085, "T5b");
    chk("T5_lit_data", last_rd, 32'hC0DE0085);
    do_read(10'h005, "T5c");
    chk("T5_lit_miss", {16'b0, miss_count}, 32'd4);
    do_read(10'h007, "T5d");
    do_read(10'h004, "T5e");
    chk("T5_lit_hit", {16'b0, hit_count}, 32'd5);
    chk("sat_lit_hit", {30'b0, s_hit}, 32'd3);
    chk("sat_lit_miss", {30'b0, s_miss}, 32'd3);

    // T6: reset while the second refill word is outstanding
    quiet = 1'b0;
    for (int w = 0; w < WPL; w++) exp_q.push_back({1'b0, 10'h200 | 10'(w), 32'h0});
    MemRead = 1'b1; WordAddress = 10'h200;
    base = acks_seen;
    for (i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (acks_seen == base + 1 && mem_req) break;
    end
    if (i >= 100) begin
      n_checks++; n_errors++;
      $display("FAIL T6_wait: got %0d acks expected word 2 in flight", acks_seen - base);
    end
    RST = 1'b1; MemRead = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    chk("T6_req", {31'b0, mem_req}, 32'd0);
    chk("T6_hits", {16'b0, hit_count}, 32'd0);
    chk("T6_misses", {16'b0, miss_count}, 32'd0);
    chk("T6_stall", {31'b0, stall}, 32'd0);
    RST = 1'b0;
    for (int j = 0; j < 32; j++) mv[j] = 1'b0;
    m_hits = 0; m_misses = 0;
    quiet = 1'b1;
    do_read(10'h200, "T6a");
    chk("T6_lit_miss1", {16'b0, miss_count}, 32'd1);
    do_read(10'h005, "T6b");
    chk("T6_lit_miss2", {16'b0, miss_count}, 32'd2);
    do_read(10'h201, "T6c");
    chk("T6_lit_hit", {16'b0, hit_count}, 32'd1);

    repeat (3) @(negedge CLK);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end
endmodule
